// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with IF/ID pipeline register.
//
// Issues one word fetch per cycle to instruction memory, absorbs memory wait
// states as bubbles, parks a completed word in a one-entry hold buffer when
// decode stalls, and applies decode redirects after one branch delay slot.
//
// Ports
//   clk            clock, all state on rising edge
//   reset          synchronous reset, active low
//   stall_D        decode hazard stall: IF/ID and PC_F hold
//   PCSrc_D[1:0]   00 seq, 01 NPC_B, 10 NPC_J, 11 NPC_JR
//   NPC_B/J/JR     redirect targets
//   imem_req       fetch request (FETCH state, out of reset)
//   imem_addr      word-aligned fetch address
//   imem_ready     memory completes the current request this cycle
//   imem_rdata     fetched word, valid with imem_ready
//   instr_D, PC_D, PC4_D, PC8_D, valid_D   IF/ID register
//   busy_F         request outstanding or hold buffer full
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_D,
    input  logic [1:0]  PCSrc_D,
    input  logic [31:0] NPC_B,
    input  logic [31:0] NPC_J,
    input  logic [31:0] NPC_JR,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC4_D,
    output logic [31:0] PC8_D,
    output logic        valid_D,
    output logic        busy_F
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] hbuf_instr_q, hbuf_instr_d;
    logic [31:0] hbuf_pc_q, hbuf_pc_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic [31:0] pc4_d_q, pc4_d_d;
    logic [31:0] pc8_d_q, pc8_d_d;
    logic        valid_d_q, valid_d_d;

    logic        fetch_done;
    logic        redirect;
    logic [31:0] target;

    always_comb begin
        fetch_done = (state_q == FETCH) && imem_ready;
        redirect   = valid_d_q && !stall_D && (PCSrc_D != 2'b00);

        case (PCSrc_D)
            2'b01:   target = NPC_B;
            2'b10:   target = NPC_J;
            2'b11:   target = NPC_JR;
            default: target = pc_f_q + 32'd4;
        endcase

        state_d      = state_q;
        pc_f_d       = pc_f_q;
        pend_vld_d   = pend_vld_q;
        pend_pc_d    = pend_pc_q;
        hbuf_instr_d = hbuf_instr_q;
        hbuf_pc_d    = hbuf_pc_q;
        instr_d_d    = instr_d_q;
        pc_d_d       = pc_d_q;
        pc4_d_d      = pc4_d_q;
        pc8_d_d      = pc8_d_q;
        valid_d_d    = valid_d_q;

        // Next PC. The word completing now is the delay slot of any redirect
        // accepted this cycle or earlier, so the redirect target follows it.
        // A redirect in the same cycle beats an older pending one.
        if (fetch_done) begin
            if (redirect)
                pc_f_d = target;
            else if (pend_vld_q)
                pc_f_d = pend_pc_q;
            else
                pc_f_d = pc_f_q + 32'd4;
            pend_vld_d = 1'b0;
        end else if (redirect) begin
            if (state_q == HOLD) begin
                // Delay slot already sits in the hold buffer and PC_F has
                // moved past it, so the target is the very next fetch.
                pc_f_d     = target;
                pend_vld_d = 1'b0;
            end else begin
                pend_vld_d = 1'b1;
                pend_pc_d  = target;
            end
        end

        // IF/ID and hold buffer
        if (state_q == FETCH) begin
            if (imem_ready && stall_D) begin
                hbuf_instr_d = imem_rdata;
                hbuf_pc_d    = pc_f_q;
                state_d      = HOLD;
            end else if (imem_ready) begin
                instr_d_d = imem_rdata;
                pc_d_d    = pc_f_q;
                pc4_d_d   = pc_f_q + 32'd4;
                pc8_d_d   = pc_f_q + 32'd8;
                valid_d_d = 1'b1;
            end else if (!stall_D) begin
                // wait state: bubble, PCs keep their last value
                instr_d_d = 32'd0;
                valid_d_d = 1'b0;
            end
        end else if (!stall_D) begin
            instr_d_d = hbuf_instr_q;
            pc_d_d    = hbuf_pc_q;
            pc4_d_d   = hbuf_pc_q + 32'd4;
            pc8_d_d   = hbuf_pc_q + 32'd8;
            valid_d_d = 1'b1;
            state_d   = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= FETCH;
            pc_f_q       <= RESET_PC;
            pend_vld_q   <= 1'b0;
            pend_pc_q    <= 32'd0;
            hbuf_instr_q <= 32'd0;
            hbuf_pc_q    <= 32'd0;
            instr_d_q    <= 32'd0;
            pc_d_q       <= 32'd0;
            pc4_d_q      <= 32'd0;
            pc8_d_q      <= 32'd0;
            valid_d_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            pend_vld_q   <= pend_vld_d;
            pend_pc_q    <= pend_pc_d;
            hbuf_instr_q <= hbuf_instr_d;
            hbuf_pc_q    <= hbuf_pc_d;
            instr_d_q    <= instr_d_d;
            pc_d_q       <= pc_d_d;
            pc4_d_q      <= pc4_d_d;
            pc8_d_q      <= pc8_d_d;
            valid_d_q    <= valid_d_d;
        end
    end

    // Gated by reset so the request drops in the reset cycle itself and
    // rises in the first cycle reset is released.
    assign imem_req  = reset && (state_q == FETCH);
    assign imem_addr = {pc_f_q[31:2], 2'b00};
    assign busy_F    = reset && ((state_q == HOLD) || !imem_ready);

    assign instr_D = instr_d_q;
    assign PC_D    = pc_d_q;
    assign PC4_D   = pc4_d_q;
    assign PC8_D   = pc8_d_q;
    assign valid_D = valid_d_q;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch. Every word loaded into
// IF/ID is predicted by pushing its PC into a scoreboard when the stimulus
// is driven; the monitor pops and compares on each non-stalled load.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_D;
    logic [1:0]  PCSrc_D;
    logic [31:0] NPC_B, NPC_J, NPC_JR;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_D, PC_D, PC4_D, PC8_D;
    logic        valid_D;
    logic        busy_F;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .stall_D(stall_D), .PCSrc_D(PCSrc_D),
        .NPC_B(NPC_B), .NPC_J(NPC_J), .NPC_JR(NPC_JR),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_D(instr_D), .PC_D(PC_D), .PC4_D(PC4_D), .PC8_D(PC8_D),
        .valid_D(valid_D), .busy_F(busy_F)
    );

    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mw(imem_addr);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, then check any IF/ID load.
    task automatic cyc(input logic st, input logic rdy, input logic [1:0] src);
        logic [31:0] e;
        stall_D    = st;
        imem_ready = rdy;
        PCSrc_D    = src;
        @(posedge clk);
        #1;
        if (reset && !st && valid_D) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("PC_D",    PC_D,    e);
                chk("instr_D", instr_D, mw(e));
                chk("PC4_D",   PC4_D,   e + 32'd4);
                chk("PC8_D",   PC8_D,   e + 32'd8);
            end
        end
        stall_D = 1'b0;
        PCSrc_D = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(0, 1, 2'b00);
        cyc(0, 1, 2'b00);
        reset = 1'b1;
        sb.delete();
    endtask

    initial begin
        reset = 1'b0; stall_D = 1'b0; PCSrc_D = 2'b00; imem_ready = 1'b1;
        NPC_B = 32'h0000_3100; NPC_J = 32'h0000_5000; NPC_JR = 32'h0000_4000;

        // reset state (imem_ready high during reset is ignored)
        cyc(0, 1, 2'b00); cyc(0, 1, 2'b00); cyc(0, 1, 2'b00);
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(valid_D),  32'd0);
        chk("rst_instr", instr_D, 32'd0);
        chk("rst_pc",    PC_D,    32'd0);
        chk("rst_pc4",   PC4_D,   32'd0);
        chk("rst_pc8",   PC8_D,   32'd0);
        chk("rst_busy",  32'(busy_F), 32'd0);
        reset = 1'b1;
        #1;
        chk("first_req",  32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0000_3000);

        // back-to-back fetches, one-cycle latency
        sb.push_back(32'h3000); cyc(0, 1, 2'b00);
        chk("seq_addr1", imem_addr, 32'h3004);
        sb.push_back(32'h3004); cyc(0, 1, 2'b00);
        chk("seq_addr2", imem_addr, 32'h3008);
        sb.push_back(32'h3008); cyc(0, 1, 2'b00);
        chk("seq_valid", 32'(valid_D), 32'd1);

        // wait states at 0x3004
        do_reset();
        sb.push_back(32'h3000); cyc(0, 1, 2'b00);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 2'b00);
            chk("bub_valid", 32'(valid_D), 32'd0);
            chk("bub_instr", instr_D, 32'd0);
            chk("bub_pc",    PC_D, 32'h3000);
            chk("bub_addr",  imem_addr, 32'h3004);
        end
        sb.push_back(32'h3004); cyc(0, 1, 2'b00);
        chk("ws_pc8", PC8_D, 32'h300C);

        // stall with the word arriving on the first stalled cycle
        cyc(1, 1, 2'b00);
        chk("hold_req",  32'(imem_req), 32'd0);
        chk("hold_busy", 32'(busy_F), 32'd1);
        chk("hold_pc",   PC_D, 32'h3004);
        cyc(1, 0, 2'b00);
        cyc(1, 1, 2'b00);
        chk("hold_pc2",  PC_D, 32'h3004);
        chk("hold_vld",  32'(valid_D), 32'd1);
        sb.push_back(32'h3008); cyc(0, 0, 2'b00);
        chk("rel_req",  32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, 32'h300C);

        // branch, target taken straight after the delay slot
        do_reset();
        sb.push_back(32'h3000); cyc(0, 1, 2'b00);
        sb.push_back(32'h3004); cyc(0, 1, 2'b01);
        chk("br_addr", imem_addr, 32'h3100);
        sb.push_back(32'h3100); cyc(0, 1, 2'b00);
        chk("br_next", imem_addr, 32'h3104);

        // jr while the delay slot waits on memory -> pending redirect
        do_reset();
        sb.push_back(32'h3000); cyc(0, 1, 2'b00);
        cyc(0, 0, 2'b11);
        chk("pend_addr", imem_addr, 32'h3004);
        chk("pend_vld",  32'(valid_D), 32'd0);
        cyc(0, 0, 2'b00);
        sb.push_back(32'h3004); cyc(0, 1, 2'b00);
        chk("jr_addr", imem_addr, 32'h4000);
        sb.push_back(32'h4000); cyc(0, 1, 2'b00);
        chk("jr_clear", imem_addr, 32'h4004);

        // jump accepted as the held delay slot is released
        do_reset();
        sb.push_back(32'h3000); cyc(0, 1, 2'b00);
        cyc(1, 1, 2'b00);
        sb.push_back(32'h3004); cyc(0, 0, 2'b10);
        chk("hj_addr", imem_addr, 32'h5000);

        // wrap at the top of the address space
        do_reset();
        NPC_J = 32'hFFFF_FFFC;
        sb.push_back(32'h3000); cyc(0, 1, 2'b00);
        sb.push_back(32'h3004); cyc(0, 1, 2'b10);
        chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        sb.push_back(32'hFFFF_FFFC); cyc(0, 1, 2'b00);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // reset in the middle of a request
        cyc(0, 0, 2'b00);
        reset = 1'b0;
        #1;
        chk("mid_req", 32'(imem_req), 32'd0);
        cyc(0, 1, 2'b00);
        chk("mid_vld", 32'(valid_D), 32'd0);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("mid_addr", imem_addr, 32'h3000);
        sb.push_back(32'h3000); cyc(0, 1, 2'b00);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-004 stall_D  input  1  hazard stall; when 1, IF/ID outputs and PC_F hold.
REQ-005 PCSrc_D  input  2  decode redirect: 00 sequential, 01 branch NPC_B, 10 jump NPC_J, 11 jump-register NPC_JR.
REQ-006 NPC_B, NPC_J, NPC_JR  input  32 each  redirect targets from decode.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  32  fetch word address, equal to {PC_F[31:2],2'b00}.
REQ-009 imem_ready  input  1  memory completes the current request this cycle; imem_rdata is valid.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instr_D, PC_D, PC4_D, PC8_D  output  32 each  IF/ID register: instruction, its PC, PC+4, PC+8.
REQ-012 valid_D  output  1  IF/ID holds a real instruction; 0 means bubble with instr_D=0.
REQ-013 busy_F  output  1  1 while a request is outstanding or the hold buffer is full.

Function
REQ-014 The FSM SHALL have two states: FETCH (imem_req=1) and HOLD (imem_req=0, buffer full).
REQ-015 In FETCH, imem_ready=1 with stall_D=0 SHALL load IF/ID with imem_rdata, PC_F, PC_F+4, PC_F+8, valid_D=1, and update PC_F to the next PC; the block stays in FETCH.
REQ-016 In FETCH, imem_ready=1 with stall_D=1 SHALL capture imem_rdata and PC_F in the hold buffer, update PC_F to the next PC, and enter HOLD.
REQ-017 In HOLD, stall_D=0 SHALL move the buffer into IF/ID with valid_D=1 and return to FETCH; while stall_D=1, HOLD persists and imem_ready is ignored.
REQ-018 In FETCH, imem_ready=0 with stall_D=0 SHALL load a bubble: valid_D=0, instr_D=0; PC_D/PC4_D/PC8_D hold.
REQ-019 stall_D=1 SHALL hold all IF/ID outputs unchanged in every state.
REQ-020 A redirect SHALL be accepted when valid_D=1, stall_D=0, and PCSrc_D!=00; the target is selected per REQ-005.
REQ-021 One branch delay slot: the fetch outstanding or in progress when the redirect is accepted completes normally, and the next PC after it equals the target.
REQ-022 If the redirect is accepted in the same cycle the delay-slot fetch completes, the target SHALL be used directly as the next PC.
REQ-023 Otherwise, the target SHALL be held in a pending-redirect register and consumed, then cleared, at the next fetch completion.
REQ-024 A redirect that is accepted while another is already pending SHALL overwrite it; the latest target wins.
REQ-025 With no redirect applicable, next PC SHALL be PC_F+4, computed modulo 2^32 so that 32'hFFFF_FFFC wraps to 0.
REQ-026 PC4_D and PC8_D SHALL be computed modulo 2^32.
REQ-027 Fetch latency SHALL be 1 cycle minimum: a request issued in cycle n with imem_ready=1 appears on instr_D in cycle n+1.

Reset
REQ-028 While reset=0, at each edge the block SHALL set PC_F=RESET_PC and state=FETCH, and clear the pending redirect and the hold buffer.
REQ-029 While reset=0, at each edge the block SHALL set valid_D=0 and instr_D=PC_D=PC4_D=PC8_D=0.
REQ-030 imem_req SHALL be 0 while reset=0.
REQ-031 Reset mid-request SHALL abandon the outstanding fetch; imem_ready in a reset cycle is ignored.
REQ-032 The first request after reset SHALL be issued, with imem_addr=RESET_PC, in the first cycle with reset=1.

Verification
REQ-033 Reset, then imem_ready tied to 1 for 3 cycles -> imem_addr 0x3000, 0x3004, 0x3008; PC_D 0x3000, 0x3004 in successive cycles with valid_D=1.
REQ-034 Test memory wait states: imem_ready=0 for 2 cycles at 0x3004 -> two bubbles (valid_D=0, instr_D=0), then PC_D=0x3004 with PC4_D=0x3008 and PC8_D=0x300C.
REQ-035 Stall while holding: stall_D=1 for 3 cycles, ready on the first -> HOLD entered, imem_req=0, IF/ID unchanged; on release the held word appears and the next imem_addr is +4.
REQ-036 Branch with delay slot: beq at 0x3000 in D, PCSrc_D=01, NPC_B=0x3100 -> fetch 0x3004 completes, then imem_addr=0x3100.
REQ-037 Pending redirect: jr accepted while the delay-slot fetch is stalled by imem_ready=0 and NPC_JR=0x4000 -> after the delay slot completes, imem_addr=0x4000 and the pending redirect clears.
REQ-038 Wrap and reset mid-op: PC_F=0xFFFF_FFFC with ready -> next imem_addr=0; reset=0 during a request -> imem_req=0, then 0x3000 on release.
